// File: rtl/mmio_timer_pkg.sv
// ============================================================================
// Module   : mmio_timer_pkg
// Brief    : Register offsets, CTRL field positions, reset values and the
//            byte-lane merge helper shared by the machine timer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mmio_timer_pkg;

    localparam logic [2:0] OFF_MTIME_LO    = 3'd0;
    localparam logic [2:0] OFF_MTIME_HI    = 3'd1;
    localparam logic [2:0] OFF_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] OFF_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] OFF_CTRL        = 3'd4;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_DIV_LSB = 16;

    localparam logic [63:0] MTIMECMP_RST = '1;
    localparam logic [31:0] CTRL_RST     = '0;

    // Replace only the byte lanes whose enable bit is set.
    function automatic logic [31:0] be_merge(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  be
    );
        logic [31:0] v;
        v = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) v[8*i +: 8] = new_val[8*i +: 8];
        end
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mmio_timer_prescaler.sv
// ============================================================================
// Module   : mmio_timer_prescaler
// Brief    : Divide-by-(div+1) tick generator; cleared on CTRL writes and held
//            at zero while disabled.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_timer_prescaler #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic             clr,
    output logic             tick
);

    localparam logic [DIV_W-1:0] c_one = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] r_pcnt;
    logic             w_at_div;

    assign w_at_div = (r_pcnt == div);
    assign tick     = en && w_at_div;

    always_ff @(posedge clk) begin
        if (rst || clr || !en || w_at_div) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + c_one;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mmio_timer.sv
// ============================================================================
// Module   : mmio_timer
// Brief    : Memory-mapped 64-bit machine timer with prescaler, compare
//            register and registered level interrupt; zero-latency reads.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_timer
    import mmio_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
    parameter int          DIV_W     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic [3:0]  byte_enable,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        timer_irq
);

    logic [63:0]      r_mtime;
    logic [63:0]      r_mtimecmp;
    logic             r_en;
    logic [DIV_W-1:0] r_div;
    logic             r_irq;

    logic [2:0]       w_off;
    logic             w_wr;
    logic             w_wr_mtlo;
    logic             w_wr_mthi;
    logic             w_wr_cmplo;
    logic             w_wr_cmphi;
    logic             w_wr_ctrl;
    logic             w_tick;
    logic [31:0]      w_ctrl_rd;
    logic [31:0]      w_ctrl_new;
    logic [63:0]      w_mtime_next;
    logic [63:0]      w_mtimecmp_next;
    logic [31:0]      w_rdata;
    logic             w_unused_bits;

    assign w_off = addr[4:2];
    assign hit   = (addr[31:5] == BASE_ADDR[31:5]);

    // An all-zero lane mask is not a write: it neither clears pcnt nor
    // suppresses the mtime increment.
    assign w_wr       = we && hit && (byte_enable != 4'b0000);
    assign w_wr_mtlo  = w_wr && (w_off == OFF_MTIME_LO);
    assign w_wr_mthi  = w_wr && (w_off == OFF_MTIME_HI);
    assign w_wr_cmplo = w_wr && (w_off == OFF_MTIMECMP_LO);
    assign w_wr_cmphi = w_wr && (w_off == OFF_MTIMECMP_HI);
    assign w_wr_ctrl  = w_wr && (w_off == OFF_CTRL);

    mmio_timer_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (r_en),
        .div  (r_div),
        .clr  (w_wr_ctrl),
        .tick (w_tick)
    );

    always_comb begin
        w_ctrl_rd                            = '0;
        w_ctrl_rd[CTRL_EN_BIT]               = r_en;
        w_ctrl_rd[CTRL_DIV_LSB +: DIV_W]     = r_div;
    end

    assign w_ctrl_new = be_merge(w_ctrl_rd, wdata, byte_enable);

    // A software write to either half wins over the tick for all 64 bits.
    always_comb begin
        w_mtime_next = r_mtime;
        if (w_wr_mtlo || w_wr_mthi) begin
            if (w_wr_mtlo) w_mtime_next[31:0]  = be_merge(r_mtime[31:0],  wdata, byte_enable);
            if (w_wr_mthi) w_mtime_next[63:32] = be_merge(r_mtime[63:32], wdata, byte_enable);
        end else if (w_tick) begin
            w_mtime_next = r_mtime + 64'd1;
        end
    end

    always_comb begin
        w_mtimecmp_next = r_mtimecmp;
        if (w_wr_cmplo) w_mtimecmp_next[31:0]  = be_merge(r_mtimecmp[31:0],  wdata, byte_enable);
        if (w_wr_cmphi) w_mtimecmp_next[63:32] = be_merge(r_mtimecmp[63:32], wdata, byte_enable);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mtime    <= '0;
            r_mtimecmp <= MTIMECMP_RST;
            r_en       <= CTRL_RST[CTRL_EN_BIT];
            r_div      <= CTRL_RST[CTRL_DIV_LSB +: DIV_W];
            r_irq      <= 1'b0;
        end else begin
            r_mtime    <= w_mtime_next;
            r_mtimecmp <= w_mtimecmp_next;
            if (w_wr_ctrl) begin
                r_en  <= w_ctrl_new[CTRL_EN_BIT];
                r_div <= w_ctrl_new[CTRL_DIV_LSB +: DIV_W];
            end
            r_irq      <= (r_mtime >= r_mtimecmp);
        end
    end

    always_comb begin
        w_rdata = '0;
        if (hit) begin
            case (w_off)
                OFF_MTIME_LO:    w_rdata = r_mtime[31:0];
                OFF_MTIME_HI:    w_rdata = r_mtime[63:32];
                OFF_MTIMECMP_LO: w_rdata = r_mtimecmp[31:0];
                OFF_MTIMECMP_HI: w_rdata = r_mtimecmp[63:32];
                OFF_CTRL:        w_rdata = w_ctrl_rd;
                default:         w_rdata = '0;
            endcase
        end
    end

    assign rdata     = w_rdata;
    assign timer_irq = r_irq;

    assign w_unused_bits = ^{addr[1:0], w_ctrl_new};

endmodule

`default_nettype wire

// File: doc/mmio_timer.md
# mmio_timer

Memory-mapped machine timer on the single-cycle core's data-memory port, beside the data RAM. It decodes the core's data address, accepts byte-enabled stores, and returns register read data combinationally in the same cycle as the load. It keeps a 64-bit free-running `mtime` with a programmable prescaler, compares it against a 64-bit `mtimecmp`, and raises a registered level interrupt.

## Interface
- `BASE_ADDR`, default 32'h2000_0000: base of a 32-byte register window, aligned to 32 bytes.
- `DIV_W`, default 16: prescaler divisor width.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `addr`  in  32  core data address (ALU result).
- `wdata`  in  32  store data, already lane-aligned.
- `we`  in  1  store strobe (core MemWrite).
- `byte_enable`  in  4  store lane mask; bit i covers `wdata[8i+7:8i]`.
- `rdata`  out  32  read data, combinational.
- `hit`  out  1  combinational; high when `addr[31:5] == BASE_ADDR[31:5]`. The top-level ReadData mux uses it.
- `timer_irq`  out  1  registered interrupt level.

## Operation
- Register map, word offset `addr[4:2]`:
  - 0: `MTIME_LO`
  - 1: `MTIME_HI`
  - 2: `MTIMECMP_LO`
  - 3: `MTIMECMP_HI`
  - 4: `CTRL`; bit0 `EN`, bits `[16 +: DIV_W]` `DIV`, all other bits read 0.
  - 5-7: reserved; reads return 0, writes are ignored.
- `addr[1:0]` is ignored.
- `rdata` is the selected register when `hit` is high, otherwise 0.
- Write: when `we && hit`, each byte lane with its `byte_enable` bit set is written. If `byte_enable` is 0, nothing changes.
- Prescaler: `pcnt` (DIV_W bits) counts when `EN` is 1.
  - `tick` is asserted when `pcnt == DIV`; in that case `pcnt` returns to 0, otherwise `pcnt` increments.
  - `DIV = 0` gives one tick per cycle. `DIV = N` gives one tick every N+1 cycles.
- `mtime` increments by 1 on each `tick`. Wrap from 64'hFFFF_FFFF_FFFF_FFFF to 0 is silent.
- Write to `MTIME_LO` or `MTIME_HI` in a cycle with `tick`:
  - The write takes effect for the written bytes.
  - The increment is dropped for all 64 bits in that cycle, so there is no carry into a freshly written half.
- `pcnt` is cleared to 0 on any write to `CTRL`, and held at 0 while `EN` is 0.
- `timer_irq <= (mtime >= mtimecmp)`, an unsigned 64-bit compare evaluated on the current register values.
- Reset values: `mtime` = 0, `mtimecmp` = all ones, `EN` = 0, `DIV` = 0, `pcnt` = 0, `timer_irq` = 0.
- Reset mid-count: all state returns to reset values on that edge. Reset overrides a simultaneous write.

## Timing
- Read latency 0: `rdata` reflects the register state at the start of the cycle. It does not show a write landing on the same edge.
- Write visible on readback in the cycle after the store edge.
- `timer_irq` lags the compare condition by exactly 1 cycle, in both the assert and deassert directions.
  - Writing `mtimecmp` above `mtime` deasserts `timer_irq` at the second edge after the store.
- 64-bit reads are not atomic. Software reads HI, LO, HI and retries if HI changed.
- No stall or handshake signals: every access completes in the core's single cycle.

## Structure
- Package `mmio_timer_pkg` holds:
  - offset constants `OFF_MTIME_LO` .. `OFF_CTRL`
  - `CTRL` bit positions
  - reset constants `MTIMECMP_RST = '1` and `CTRL_RST = '0`
  - a `be_merge(old, new, be)` function for byte-lane writes
- One sub-module, `mmio_timer_prescaler`: inputs `clk`, `rst`, `en`, `div`, `clr`; outputs `tick`.
- The compare, register file and read mux stay in `mmio_timer`.

## Test plan
- Reset, then read all five registers.
  - Required: `MTIME` = 0, `MTIMECMP` = 0xFFFF_FFFF on both halves, `CTRL` = 0, `timer_irq` = 0, `hit` = 0 for `addr` 0x1000_0000.
- Write `CTRL` = 0x0003_0001 (`EN`=1, `DIV`=3). Run 40 cycles.
  - Required: `MTIME_LO` = 10, with increments every 4th cycle.
- Write `MTIMECMP_HI` = 0, then `MTIMECMP_LO` = 5. Set `EN`=1, `DIV`=0.
  - Required: `timer_irq` rises exactly 1 cycle after `mtime` reaches 5.
  - Then write `MTIMECMP_LO` = 0x100. Required: `timer_irq` falls 2 edges after that store.
- Write `MTIME_LO` = 0xFFFF_FFFF with `EN`=1, `DIV`=0.
  - Required: at the next tick `MTIME_HI` = 1 and `MTIME_LO` = 0.
  - Then write `MTIME_LO` with `byte_enable` 4'b0010 and `wdata` 0x0000_AB00 on a tick cycle. Required: `MTIME_LO` = 0x0000_AB00 and no increment that cycle.
- Write `wdata` 0xDEAD_BEEF to offset 0x14 and to offset 0x1C.
  - Required: reads return 0 and no other register changes.
- Assert `rst` for one cycle during a write to `CTRL`.
  - Required: `CTRL` = 0 and `mtime` = 0 afterwards.
